matrix_result_serializer: RTL

MATRIX_RESULT_SERIALIZER -- requirements
Module: matrix_result_serializer

---
 rtl/matrix_result_serializer_if.sv | 17 +
 rtl/matrix_result_serializer.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/matrix_result_serializer_if.sv
// ============================================================================
// Module   : matrix_result_serializer_if
// Purpose  : Valid/ready byte stream from the serializer to a byte sink.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface matrix_result_serializer_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

`default_nettype wire

// File: rtl/matrix_result_serializer.sv
// ============================================================================
// Module   : matrix_result_serializer
// Purpose  : Frames a 3x3 16-bit result matrix as HEADER, 18 data bytes, XOR.
// Revision : 1.0
// ============================================================================
`default_nettype none

module matrix_result_serializer #(
  parameter logic [7:0] HEADER = 8'hA5
) (
  input  wire logic                    clk,
  input  wire logic                    rst,
  input  wire logic [15:0]             c0,
  input  wire logic [15:0]             c1,
  input  wire logic [15:0]             c2,
  input  wire logic [15:0]             c3,
  input  wire logic [15:0]             c4,
  input  wire logic [15:0]             c5,
  input  wire logic [15:0]             c6,
  input  wire logic [15:0]             c7,
  input  wire logic [15:0]             c8,
  input  wire logic                    done,
  matrix_result_serializer_if.master   tx,
  output logic                         busy,
  output logic                         frame_sent,
  output logic                         overrun,
  output logic [15:0]                  frame_count
);

  localparam logic [4:0] c_LAST_IDX = 5'd17;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2,
    CHK  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        done_q, done_d;
  logic [4:0]  idx_q, idx_d;
  logic [7:0]  chk_q, chk_d;
  logic [15:0] mat_q [9];
  logic [15:0] mat_d [9];
  logic        frame_sent_q, frame_sent_d;
  logic        overrun_q, overrun_d;
  logic [15:0] frame_count_q, frame_count_d;

  logic        w_trigger;
  logic        w_valid;
  logic        w_xfer;
  logic [15:0] w_word;
  logic [7:0]  w_data_byte;
  logic [7:0]  w_tx_data;

  always_comb begin
    w_trigger   = done & ~done_q;
    w_valid     = (state_q != IDLE);
    w_xfer      = w_valid & tx.tx_ready;
    // Even index selects the high byte of the word so each word goes out MSB first.
    w_word      = mat_q[idx_q[4:1]];
    w_data_byte = idx_q[0] ? w_word[7:0] : w_word[15:8];

    unique case (state_q)
      HDR:     w_tx_data = HEADER;
      DATA:    w_tx_data = w_data_byte;
      CHK:     w_tx_data = chk_q;
      default: w_tx_data = 8'h00;
    endcase

    state_d       = state_q;
    done_d        = done;
    idx_d         = idx_q;
    chk_d         = chk_q;
    mat_d         = mat_q;
    frame_sent_d  = 1'b0;
    frame_count_d = frame_count_q;
    // A rising done while a frame is in flight (including its final CHK beat) is dropped.
    overrun_d     = overrun_q | (w_trigger & w_valid);

    unique case (state_q)
      IDLE: begin
        if (w_trigger) begin
          mat_d   = '{c0, c1, c2, c3, c4, c5, c6, c7, c8};
          idx_d   = 5'd0;
          chk_d   = 8'h00;
          state_d = HDR;
        end
      end
      HDR: begin
        if (w_xfer) state_d = DATA;
      end
      DATA: begin
        if (w_xfer) begin
          chk_d = chk_q ^ w_data_byte;
          if (idx_q == c_LAST_IDX) begin
            idx_d   = 5'd0;
            state_d = CHK;
          end else begin
            idx_d = idx_q + 5'd1;
          end
        end
      end
      CHK: begin
        if (w_xfer) begin
          state_d       = IDLE;
          frame_sent_d  = 1'b1;
          frame_count_d = frame_count_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      done_q        <= 1'b0;
      idx_q         <= 5'd0;
      chk_q         <= 8'h00;
      mat_q         <= '{default: 16'h0000};
      frame_sent_q  <= 1'b0;
      overrun_q     <= 1'b0;
      frame_count_q <= 16'h0000;
    end else begin
      state_q       <= state_d;
      done_q        <= done_d;
      idx_q         <= idx_d;
      chk_q         <= chk_d;
      mat_q         <= mat_d;
      frame_sent_q  <= frame_sent_d;
      overrun_q     <= overrun_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign tx.tx_data  = w_tx_data;
  assign tx.tx_valid = w_valid;
  assign busy        = w_valid;
  assign frame_sent  = frame_sent_q;
  assign overrun     = overrun_q;
  assign frame_count = frame_count_q;

endmodule

`default_nettype wire
